pc_unit: RTL and testbench

- Registered program-counter unit for the single-cycle/multi-cycle MIPS core.
- Holds the PC and computes the next PC from branch, jump, jal and jr controls, with stall and exception redirect.
- Adds a parametrised return-address stack (RAS) that tracks jal/jr pairs and flags return mismatches for debug and future prediction.
- Sits between the controller/ALU zero flag and instruction memory, and replaces the purely combinational next-PC mux.

---
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Registered program counter with next-PC selection and a circular return-address stack.
// Optional macro PC_ALIGN_CHECK_EN: a misaligned jr target traps to EXC_PC and pulses addr_err.
module pc_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  instr,
  input  logic                         stall,
  input  logic                         exc_valid,
  input  logic                         branch_taken,
  input  logic                         jump,
  input  logic                         jal,
  input  logic                         jr,
  input  logic [ADDR_W-1:0]            jr_target,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pc_plus4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_miss,
  output logic                         addr_err
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     ptr_q, ptr_d, ptr_m1;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              miss_q, miss_d;
  logic              aerr_q, aerr_d;
  logic              push;
  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];

  logic [31:0]       pp4_ext, br_tgt32, jmp_tgt32;
  logic [ADDR_W-1:0] br_tgt, jmp_tgt, jr_pc;
  logic              jr_bad;
  logic              unused_instr;

  assign pc_plus4  = pc_q + ADDR_W'(4);
  // Widen to 32 bits so the [31:28] splice is legal for every ADDR_W in 28..32.
  assign pp4_ext   = 32'(pc_plus4);
  assign br_tgt32  = pp4_ext + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_tgt32 = {pp4_ext[31:28], instr[25:0], 2'b00};
  assign br_tgt    = br_tgt32[ADDR_W-1:0];
  assign jmp_tgt   = jmp_tgt32[ADDR_W-1:0];
  assign ptr_m1    = ptr_q - PW'(1);
  assign unused_instr = ^instr[31:26];

`ifdef PC_ALIGN_CHECK_EN
  assign jr_bad = |jr_target[1:0];
  assign jr_pc  = jr_target;
`else
  assign jr_bad = 1'b0;
  assign jr_pc  = {jr_target[ADDR_W-1:2], 2'b00};
`endif

  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    miss_d = 1'b0;
    aerr_d = 1'b0;
    push   = 1'b0;
    if (exc_valid) begin
      pc_d = EXC_PC[ADDR_W-1:0];
    end else if (stall) begin
      pc_d = pc_q;
    end else if (branch_taken) begin
      pc_d = br_tgt;
    end else if (jr) begin
      if (jr_bad) begin
        pc_d   = EXC_PC[ADDR_W-1:0];
        aerr_d = 1'b1;
      end else begin
        pc_d = jr_pc;
        if (cnt_q != '0) begin
          ptr_d  = ptr_m1;
          cnt_d  = cnt_q - CW'(1);
          miss_d = (ras_mem_q[ptr_m1] != jr_target);
        end else begin
          miss_d = 1'b1;
        end
      end
    end else if (jump) begin
      pc_d = jmp_tgt;
      if (jal) begin
        // Full stack wraps and overwrites the oldest entry; count saturates.
        push  = 1'b1;
        ptr_d = ptr_q + PW'(1);
        if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end
    end else begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC[ADDR_W-1:0];
      ptr_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      aerr_q <= aerr_d;
    end
  end

  // Entries are don't-care after reset; only ptr/count define validity.
  always_ff @(posedge clk) begin
    if (push) ras_mem_q[ptr_q] <= pc_plus4;
  end

  assign pc        = pc_q;
  assign ras_count = cnt_q;
  assign ras_miss  = miss_q;
  assign addr_err  = aerr_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed + random bench for pc_unit against a queue-based behavioural model.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        stall = 1'b0, exc_valid = 1'b0, branch_taken = 1'b0;
  logic        jump = 1'b0, jal = 1'b0, jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc, pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_miss, addr_err;

  int tests = 0;
  int fails = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // Behavioural model: PC as a plain number, RAS as a bounded queue (back = top).
  logic [31:0] m_pc;
  logic [31:0] ras[$];
  logic        e_miss, e_aerr;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .stall(stall), .exc_valid(exc_valid),
    .branch_taken(branch_taken), .jump(jump), .jal(jal), .jr(jr), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count), .ras_miss(ras_miss), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".cnt"}, 32'(ras_count), ras.size());
    chk({tag, ".miss"}, 32'(ras_miss), 32'(e_miss));
    chk({tag, ".aerr"}, 32'(addr_err), 32'(e_aerr));
  endtask

  task automatic m_reset();
    m_pc = 32'h3000;
    ras.delete();
    e_miss = 1'b0;
    e_aerr = 1'b0;
  endtask

  task automatic step(input string tag, input logic st, input logic ex, input logic br,
                      input logic jp, input logic jl, input logic r,
                      input logic [31:0] ins, input logic [31:0] jt);
    logic [31:0] pp4, top;
    stall = st; exc_valid = ex; branch_taken = br; jump = jp; jal = jl; jr = r;
    instr = ins; jr_target = jt;
    pp4 = m_pc + 32'd4;
    e_miss = 1'b0;
    e_aerr = 1'b0;
    if (ex) m_pc = 32'h4180;
    else if (st) m_pc = m_pc;
    else if (br) m_pc = pp4 + ($signed({{16{ins[15]}}, ins[15:0]}) * 4);
    else if (r) begin
      if (ALIGN && jt[1:0] != 2'b00) begin
        m_pc = 32'h4180;
        e_aerr = 1'b1;
      end else begin
        m_pc = ALIGN ? jt : (jt & ~32'd3);
        if (ras.size() > 0) begin
          top = ras.pop_back();
          e_miss = (top != jt);
        end else e_miss = 1'b1;
      end
    end else if (jp) begin
      m_pc = {pp4[31:28], ins[25:0], 2'b00};
      if (jl) begin
        ras.push_back(pp4);
        if (ras.size() > 4) void'(ras.pop_front());
      end
    end else m_pc = pp4;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic jal_to(input string tag, input logic [31:0] tgt);
    step(tag, 0, 0, 0, 1, 1, 0, {6'h03, tgt[27:2]}, 32'h0);
  endtask

  task automatic jmp_to(input string tag, input logic [31:0] tgt);
    step(tag, 0, 0, 0, 1, 0, 0, {6'h02, tgt[27:2]}, 32'h0);
  endtask

  task automatic jr_to(input string tag, input logic [31:0] tgt);
    step(tag, 0, 0, 0, 0, 0, 1, 32'h0, tgt);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle sequence then branch with lower-priority jump/jal ignored.
    idle("idle1"); idle("idle2"); idle("idle3"); idle("idle4");
    step("br_over_jal", 0, 0, 1, 1, 1, 0, 32'h0C00_FFFC, 32'h0);
    step("jal_no_jump", 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);

    // Push then matching pop.
    apply_reset();
    step("jal_1000", 0, 0, 0, 1, 1, 0, 32'h0C00_0400, 32'h0);
    idle("idle_push");
    jr_to("jr_match", 32'h3004);

    // Overflow then drain, then underflow.
    for (int i = 0; i < 5; i++) jal_to($sformatf("push%0d", i), 32'h0000_2000 + 32'(i) * 32'h40);
    for (int i = 0; i < 4; i++) jr_to($sformatf("pop%0d", i), ras[$]);
    jr_to("underflow", 32'h0000_5000);
    idle("miss_clear");
    jal_to("push_w", 32'h0000_2400);
    jr_to("jr_wrong", 32'h0000_7777_0000 | 32'h10);

    // Stall hold and exception overriding stall.
    jmp_to("to_3020", 32'h3020);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("stall_jal", 1, 0, 0, 1, 1, 0, 32'h0C00_0100, 32'h0);
    jal_to("push_exc", 32'h0000_2800);
    step("exc_stall", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Misaligned jr target.
    jal_to("push_mis", 32'h0000_1000);
    jr_to("jr_misalign", 32'h3006);
    idle("after_mis");

    // Random traffic: rare exceptions, jr targets often taken from the model's top.
    for (int i = 0; i < 300; i++) begin
      logic st, ex, br, jp, jl, r;
      st = ($urandom_range(0, 9) == 0);
      ex = ($urandom_range(0, 24) == 0);
      br = ($urandom_range(0, 6) == 0);
      jp = ($urandom_range(0, 3) == 0);
      jl = ($urandom_range(0, 1) == 0);
      r  = ($urandom_range(0, 3) == 0);
      t  = $urandom;
      if (ras.size() > 0 && $urandom_range(0, 2) != 0) t = ras[$];
      else if ($urandom_range(0, 1) == 0) t = t & ~32'd3;
      step($sformatf("rnd%0d", i), st, ex, br, jp, jl, r, $urandom, t);
      if ($urandom_range(0, 60) == 0) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
